// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Purpose:
//   Sits behind a simple CPU memory controller and answers its byte-wide bus
//   transactions. Low addresses map to a byte RAM. The window where
//   mem_addr[17:16] == 2'b11 is a small IO space:
//     0x30000 write : push a byte into the UART transmit FIFO
//     0x30000 read  : consume the waiting UART receive byte (0 if none)
//     0x30004 write : raise the sticky program-end flag (halt)
//     0x30004 read  : status byte {6'b0, tx FIFO full, rx byte waiting}
//   Any other IO offset reads as zero and ignores writes.
//
// Ports:
//   clk_in         single clock, all state changes on its rising edge
//   rst_in         synchronous active-high reset (RAM contents are kept)
//   rdy_in         global enable; while low nothing commits and state holds
//   mem_addr       byte address from the controller
//   mem_write      write data byte
//   r_nw_in        1 = read, 0 = write
//   mem_read       read data byte, valid the cycle after a committed read
//   io_buffer_full back-pressure, asserted early enough to cover a write
//                  already in flight
//   tx_data        UART transmit byte (head of the TX FIFO, 0 when empty)
//   tx_valid       TX FIFO holds at least one byte
//   tx_ready       UART sink takes tx_data this cycle
//   rx_data        UART received byte
//   rx_valid       rx_data is waiting; held by the source until popped
//   rx_pop         one-cycle pulse in the cycle that consumes rx_data
//   halt           program-end flag, stays set until reset
// -----------------------------------------------------------------------------
module mem_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int TX_DEPTH   = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_addr,
  input  logic [7:0]  mem_write,
  input  logic        r_nw_in,
  output logic [7:0]  mem_read,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        halt
);

  localparam int PTR_W = $clog2(TX_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(TX_DEPTH);
  // Two slots of headroom: the controller may already have a write on the
  // bus when it first sees the flag, plus the flag itself is registered.
  localparam logic [CNT_W-1:0] FULL_MARK = CNT_W'(TX_DEPTH - 2);

  localparam logic [15:0] IO_UART_OFF = 16'h0000;
  localparam logic [15:0] IO_CTRL_OFF = 16'h0004;

  // Storage: neither array is reset, only the bookkeeping around it.
  logic [7:0]            r_ram [0:(2**ADDR_WIDTH)-1];
  logic [7:0]            r_fifo [0:TX_DEPTH-1];

  logic [PTR_W-1:0]      r_wrPtr;
  logic [PTR_W-1:0]      r_rdPtr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_ioFull;
  logic                  r_halt;
  logic [7:0]            r_ramQ;
  logic [7:0]            r_ioQ;
  logic                  r_selRam;

  logic                  w_commit;
  logic                  w_isIo;
  logic [15:0]           w_ioOff;
  logic                  w_ioUart;
  logic                  w_ioCtrl;
  logic                  w_addrZero;
  logic [ADDR_WIDTH-1:0] w_ramAddr;
  logic                  w_ramWe;
  logic                  w_fifoFull;
  logic                  w_txPop;
  logic                  w_txPush;
  logic                  w_haltSet;
  logic [CNT_W-1:0]      w_countNext;
  logic [7:0]            w_ioReadByte;

  // Reset wins over everything, so a transaction only commits when the
  // global enable is high and reset is not being applied.
  assign w_commit   = rdy_in & ~rst_in;

  assign w_isIo     = (mem_addr[17:16] == 2'b11);
  assign w_ioOff    = mem_addr[15:0];
  assign w_ioUart   = w_isIo & (w_ioOff == IO_UART_OFF);
  assign w_ioCtrl   = w_isIo & (w_ioOff == IO_CTRL_OFF);
  // The idle bus looks like a write of 0 to address 0, so that exact
  // address must never modify RAM.
  assign w_addrZero = (mem_addr == 32'h0000_0000);
  assign w_ramAddr  = mem_addr[ADDR_WIDTH-1:0];
  assign w_ramWe    = w_commit & ~r_nw_in & ~w_isIo & ~w_addrZero;

  assign w_fifoFull = (r_count == DEPTH_C);
  assign tx_valid   = (r_count != '0);
  assign tx_data    = tx_valid ? r_fifo[r_rdPtr] : 8'h00;

  // A pop in the same cycle frees a slot, so a push into a full FIFO is
  // still accepted when the sink is draining it.
  assign w_txPop    = w_commit & tx_valid & tx_ready;
  assign w_txPush   = w_commit & ~r_nw_in & w_ioUart & (~w_fifoFull | w_txPop);
  assign w_haltSet  = w_commit & ~r_nw_in & w_ioCtrl;

  // rx_pop is combinational so the source sees the consume in the very
  // cycle the read commits and can drop rx_valid at that edge.
  assign rx_pop     = w_commit & r_nw_in & w_ioUart & rx_valid;

  assign io_buffer_full = r_ioFull;
  assign halt           = r_halt;

  // mem_read is a pick between two registered bytes: the RAM read port
  // (kept reset-free so it maps onto block RAM) and the IO/zero byte.
  assign mem_read = r_selRam ? r_ramQ : r_ioQ;

  // FIFO occupancy after this edge.
  always_comb begin
    w_countNext = r_count;
    if (w_txPush && !w_txPop) begin
      w_countNext = r_count + CNT_W'(1);
    end else if (w_txPop && !w_txPush) begin
      w_countNext = r_count - CNT_W'(1);
    end
  end

  // Byte returned by an IO read; writes and RAM reads leave it at zero.
  always_comb begin
    w_ioReadByte = 8'h00;
    if (r_nw_in && w_isIo) begin
      if (w_ioUart) begin
        w_ioReadByte = rx_valid ? rx_data : 8'h00;
      end else if (w_ioCtrl) begin
        w_ioReadByte = {6'b00_0000, w_fifoFull, rx_valid};
      end
    end
  end

  // RAM array with a synchronous read port.
  always_ff @(posedge clk_in) begin
    if (w_ramWe) begin
      r_ram[w_ramAddr] <= mem_write;
    end
    if (w_commit) begin
      r_ramQ <= r_ram[w_ramAddr];
    end
  end

  // TX FIFO storage; slot selection comes from the write pointer below.
  always_ff @(posedge clk_in) begin
    if (w_txPush) begin
      r_fifo[r_wrPtr] <= mem_write;
    end
  end

  // Control state: FIFO pointers and count, back-pressure, halt flag and
  // the read-data selection. Pointers wrap naturally because TX_DEPTH is a
  // power of two.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_wrPtr  <= '0;
      r_rdPtr  <= '0;
      r_count  <= '0;
      r_ioFull <= 1'b0;
      r_halt   <= 1'b0;
      r_ioQ    <= 8'h00;
      r_selRam <= 1'b0;
    end else begin
      if (w_txPush) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_txPop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      r_count  <= w_countNext;
      r_ioFull <= (w_countNext >= FULL_MARK);
      if (w_haltSet) begin
        r_halt <= 1'b1;
      end
      if (w_commit) begin
        r_selRam <= r_nw_in & ~w_isIo;
        r_ioQ    <= w_ioReadByte;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//
// Self-checking bench for mem_responder. A behavioural model (associative
// array for RAM, queue for the TX FIFO, a sticky halt bit and the expected
// read byte) is advanced once per clock edge from the bench's own inputs and
// compared against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_mem_responder;

  localparam int DEPTH = 8;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] mem_addr;
  logic [7:0]  mem_write;
  logic        r_nw_in;
  logic [7:0]  mem_read;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_pop;
  logic        halt;

  int totalChecks = 0;
  int badChecks   = 0;

  logic [7:0] modelRam [int];
  logic [7:0] txQ [$];
  logic       modelHalt = 1'b0;
  logic [7:0] expRead = 8'h00;
  bit         expReadKnown = 1'b0;

  mem_responder #(.ADDR_WIDTH(17), .TX_DEPTH(DEPTH)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .mem_addr      (mem_addr),
    .mem_write     (mem_write),
    .r_nw_in       (r_nw_in),
    .mem_read      (mem_read),
    .io_buffer_full(io_buffer_full),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_pop        (rx_pop),
    .halt          (halt)
  );

  always #5 clk_in = ~clk_in;

  // Drive one bus transaction shortly after the previous edge.
  task automatic applyStimulus(input logic rst, input logic rdy, input logic [31:0] addr,
                               input logic [7:0] data, input logic rnw);
    rst_in    = rst;
    rdy_in    = rdy;
    mem_addr  = addr;
    mem_write = data;
    r_nw_in   = rnw;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Advance the reference model by one clock edge using the inputs now driven.
  function automatic void modelStep();
    int         sizeBefore;
    logic       io;
    logic [15:0] off;
    int         ramKey;
    if (rst_in) begin
      txQ.delete();
      modelHalt    = 1'b0;
      expRead      = 8'h00;
      expReadKnown = 1'b1;
      return;
    end
    if (!rdy_in) return;
    sizeBefore = txQ.size();
    io     = (mem_addr[17:16] == 2'b11);
    off    = mem_addr[15:0];
    ramKey = int'(mem_addr[16:0]);
    if (tx_ready && sizeBefore != 0) void'(txQ.pop_front());
    if (r_nw_in) begin
      expReadKnown = 1'b1;
      if (io) begin
        if (off == 16'h0000) expRead = rx_valid ? rx_data : 8'h00;
        else if (off == 16'h0004) expRead = {6'b0, (sizeBefore == DEPTH), rx_valid};
        else expRead = 8'h00;
      end else if (modelRam.exists(ramKey)) begin
        expRead = modelRam[ramKey];
      end else begin
        expReadKnown = 1'b0;
      end
    end else begin
      expRead      = 8'h00;
      expReadKnown = 1'b1;
      if (mem_addr != 32'h0) begin
        if (io) begin
          if (off == 16'h0000 && txQ.size() < DEPTH) txQ.push_back(mem_write);
          else if (off == 16'h0004) modelHalt = 1'b1;
        end else begin
          modelRam[ramKey] = mem_write;
        end
      end
    end
  endfunction

  task automatic doReset();
    applyStimulus(1'b1, 1'b1, 32'h0, 8'h00, 1'b0);
    modelStep();
    tick();
  endtask

  task automatic test_reset();
    tx_ready = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'h99;
    applyStimulus(1'b1, 1'b1, 32'h0003_0000, 8'h00, 1'b1);
    totalChecks++;
    if (rx_pop !== 1'b0) begin
      badChecks++;
      $display("[TB] FAIL reset_rx_pop actual=%b expected=0", rx_pop);
    end
    modelStep();
    tick();
    totalChecks++;
    if (mem_read !== 8'h00) begin
      badChecks++;
      $display("[TB] FAIL reset_mem_read actual=%h expected=00", mem_read);
    end
    totalChecks++;
    if (io_buffer_full !== 1'b0) begin
      badChecks++;
      $display("[TB] FAIL reset_full actual=%b expected=0", io_buffer_full);
    end
    totalChecks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      badChecks++;
      $display("[TB] FAIL reset_tx actual=%b/%h expected=0/00", tx_valid, tx_data);
    end
    applyStimulus(1'b1, 1'b1, 32'h0003_0004, 8'h01, 1'b0);
    modelStep();
    tick();
    totalChecks++;
    if (halt !== 1'b0) begin
      badChecks++;
      $display("[TB] FAIL reset_halt_write actual=%b expected=0", halt);
    end
    applyStimulus(1'b1, 1'b1, 32'h0003_0000, 8'h42, 1'b0);
    modelStep();
    tick();
    totalChecks++;
    if (tx_valid !== 1'b0) begin
      badChecks++;
      $display("[TB] FAIL reset_tx_push actual=%b expected=0", tx_valid);
    end
    rx_valid = 1'b0;
  endtask

  task automatic test_ram_basic();
    applyStimulus(1'b0, 1'b1, 32'h0000_0010, 8'hA5, 1'b0);
    modelStep();
    tick();
    totalChecks++;
    if (mem_read !== 8'h00) begin
      badChecks++;
      $display("[TB] FAIL ram_after_write actual=%h expected=00", mem_read);
    end
    applyStimulus(1'b0, 1'b1, 32'h0000_0010, 8'h00, 1'b1);
    modelStep();
    tick();
    totalChecks++;
    if (mem_read !== 8'hA5) begin
      badChecks++;
      $display("[TB] FAIL ram_readback actual=%h expected=a5", mem_read);
    end
    // Disabled cycle: a different read must not disturb mem_read.
    applyStimulus(1'b0, 1'b0, 32'h0000_0020, 8'h00, 1'b1);
    modelStep();
    tick();
    totalChecks++;
    if (mem_read !== 8'hA5) begin
      badChecks++;
      $display("[TB] FAIL ram_hold_rdy0 actual=%h expected=a5", mem_read);
    end
  endtask

  task automatic test_addr_zero();
    logic [7:0] preload;
    applyStimulus(1'b0, 1'b1, 32'h0, 8'h00, 1'b1);
    modelStep();
    tick();
    preload = mem_read;
    applyStimulus(1'b0, 1'b1, 32'h0, 8'h55, 1'b0);
    modelStep();
    tick();
    applyStimulus(1'b0, 1'b1, 32'h0, 8'h00, 1'b1);
    modelStep();
    tick();
    totalChecks++;
    if (mem_read !== preload || mem_read === 8'h55) begin
      badChecks++;
      $display("[TB] FAIL addr_zero_discard actual=%h expected=%h", mem_read, preload);
    end
  endtask

  task automatic test_rx();
    rx_valid = 1'b1;
    rx_data  = 8'h3C;
    applyStimulus(1'b0, 1'b0, 32'h0003_0000, 8'h00, 1'b1);
    totalChecks++;
    if (rx_pop !== 1'b0) begin
      badChecks++;
      $display("[TB] FAIL rx_pop_rdy0 actual=%b expected=0", rx_pop);
    end
    modelStep();
    tick();
    applyStimulus(1'b0, 1'b1, 32'h0003_0000, 8'h00, 1'b1);
    totalChecks++;
    if (rx_pop !== 1'b1) begin
      badChecks++;
      $display("[TB] FAIL rx_pop_pulse actual=%b expected=1", rx_pop);
    end
    modelStep();
    tick();
    totalChecks++;
    if (mem_read !== 8'h3C) begin
      badChecks++;
      $display("[TB] FAIL rx_data_read actual=%h expected=3c", mem_read);
    end
    rx_valid = 1'b0;
    applyStimulus(1'b0, 1'b1, 32'h0003_0000, 8'h00, 1'b1);
    totalChecks++;
    if (rx_pop !== 1'b0) begin
      badChecks++;
      $display("[TB] FAIL rx_no_pop actual=%b expected=0", rx_pop);
    end
    modelStep();
    tick();
    totalChecks++;
    if (mem_read !== 8'h00) begin
      badChecks++;
      $display("[TB] FAIL rx_empty_read actual=%h expected=00", mem_read);
    end
  endtask

  task automatic test_tx_fill();
    doReset();
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h0003_0000, 8'(i), 1'b0);
      modelStep();
      tick();
      totalChecks++;
      if (io_buffer_full !== (i >= 6)) begin
        badChecks++;
        $display("[TB] FAIL tx_fill_full push=%0d actual=%b expected=%b", i, io_buffer_full, (i >= 6));
      end
    end
    applyStimulus(1'b0, 1'b1, 32'h0003_0004, 8'h00, 1'b1);
    modelStep();
    tick();
    totalChecks++;
    if (mem_read !== 8'h02) begin
      badChecks++;
      $display("[TB] FAIL tx_fill_status actual=%h expected=02", mem_read);
    end
    tx_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b0, 1'b1, 32'h0, 8'h00, 1'b0);
      totalChecks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'(k)) begin
        badChecks++;
        $display("[TB] FAIL tx_drain idx=%0d actual=%b/%h expected=1/%h", k, tx_valid, tx_data, 8'(k));
      end
      modelStep();
      tick();
    end
    totalChecks++;
    if (tx_valid !== 1'b0 || io_buffer_full !== 1'b0) begin
      badChecks++;
      $display("[TB] FAIL tx_drained actual=%b/%b expected=0/0", tx_valid, io_buffer_full);
    end
  endtask

  task automatic test_push_pop_full();
    logic [7:0] lastByte;
    doReset();
    tx_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h0003_0000, 8'($urandom_range(1, 255)), 1'b0);
      modelStep();
      tick();
    end
    tx_ready = 1'b1;
    applyStimulus(1'b0, 1'b1, 32'h0003_0000, 8'h77, 1'b0);
    modelStep();
    tick();
    tx_ready = 1'b0;
    applyStimulus(1'b0, 1'b1, 32'h0003_0004, 8'h00, 1'b1);
    modelStep();
    tick();
    totalChecks++;
    if (mem_read !== 8'h02 || io_buffer_full !== 1'b1) begin
      badChecks++;
      $display("[TB] FAIL pushpop_still_full actual=%h/%b expected=02/1", mem_read, io_buffer_full);
    end
    tx_ready = 1'b1;
    lastByte = 8'h00;
    for (int k = 0; k < DEPTH; k++) begin
      applyStimulus(1'b0, 1'b1, 32'h0, 8'h00, 1'b0);
      totalChecks++;
      if (tx_valid !== 1'b1 || tx_data !== txQ[0]) begin
        badChecks++;
        $display("[TB] FAIL pushpop_order idx=%0d actual=%h expected=%h", k, tx_data, txQ[0]);
      end
      lastByte = tx_data;
      modelStep();
      tick();
    end
    totalChecks++;
    if (lastByte !== 8'h77) begin
      badChecks++;
      $display("[TB] FAIL pushpop_last actual=%h expected=77", lastByte);
    end
  endtask

  task automatic test_halt();
    doReset();
    applyStimulus(1'b0, 1'b0, 32'h0003_0004, 8'hFF, 1'b0);
    modelStep();
    tick();
    totalChecks++;
    if (halt !== 1'b0) begin
      badChecks++;
      $display("[TB] FAIL halt_rdy0 actual=%b expected=0", halt);
    end
    applyStimulus(1'b0, 1'b1, 32'h0003_0004, 8'hFF, 1'b0);
    modelStep();
    tick();
    applyStimulus(1'b0, 1'b1, 32'h0, 8'h00, 1'b0);
    modelStep();
    tick();
    totalChecks++;
    if (halt !== 1'b1) begin
      badChecks++;
      $display("[TB] FAIL halt_set actual=%b expected=1", halt);
    end
    doReset();
    totalChecks++;
    if (halt !== 1'b0) begin
      badChecks++;
      $display("[TB] FAIL halt_reset actual=%b expected=0", halt);
    end
  endtask

  task automatic test_random_traffic();
    logic [31:0] pool [8];
    logic [31:0] addr;
    logic [7:0]  data;
    logic        rnw;
    logic        rdy;
    logic        expPop;
    logic [7:0]  expTx;
    int          op;
    doReset();
    for (int i = 0; i < 8; i++) pool[i] = {15'b0, 17'($urandom_range(1, 32'h1FFFF))};
    for (int n = 0; n < 400; n++) begin
      rdy      = ($urandom_range(0, 3) != 0);
      tx_ready = $urandom_range(0, 1);
      rx_valid = $urandom_range(0, 1);
      rx_data  = 8'($urandom);
      data     = 8'($urandom);
      op       = $urandom_range(0, 9);
      case (op)
        0, 1: begin addr = pool[$urandom_range(0, 7)]; rnw = 1'b0; end
        2, 3: begin addr = pool[$urandom_range(0, 7)]; rnw = 1'b1; end
        4, 5: begin addr = 32'h0003_0000; rnw = 1'b0; end
        6:    begin addr = 32'h0003_0000; rnw = 1'b1; end
        7:    begin addr = 32'h0003_0004; rnw = 1'b1; end
        8:    begin addr = 32'h0003_0008; rnw = $urandom_range(0, 1); end
        default: begin
          addr = ($urandom_range(0, 15) == 0) ? 32'h0003_0004 : 32'h0;
          rnw  = 1'b0;
        end
      endcase
      applyStimulus(1'b0, rdy, addr, data, rnw);
      expPop = rdy && rnw && (addr == 32'h0003_0000) && rx_valid;
      expTx  = (txQ.size() != 0) ? txQ[0] : 8'h00;
      totalChecks++;
      if (rx_pop !== expPop) begin
        badChecks++;
        $display("[TB] FAIL rand_rx_pop cyc=%0d actual=%b expected=%b", n, rx_pop, expPop);
      end
      totalChecks++;
      if (tx_valid !== (txQ.size() != 0) || tx_data !== expTx) begin
        badChecks++;
        $display("[TB] FAIL rand_tx cyc=%0d actual=%b/%h expected=%b/%h", n, tx_valid, tx_data,
                 (txQ.size() != 0), expTx);
      end
      modelStep();
      tick();
      if (expReadKnown) begin
        totalChecks++;
        if (mem_read !== expRead) begin
          badChecks++;
          $display("[TB] FAIL rand_mem_read cyc=%0d actual=%h expected=%h", n, mem_read, expRead);
        end
      end
      totalChecks++;
      if (io_buffer_full !== (txQ.size() >= DEPTH - 2)) begin
        badChecks++;
        $display("[TB] FAIL rand_full cyc=%0d actual=%b expected=%b", n, io_buffer_full,
                 (txQ.size() >= DEPTH - 2));
      end
      totalChecks++;
      if (halt !== modelHalt) begin
        badChecks++;
        $display("[TB] FAIL rand_halt cyc=%0d actual=%b expected=%b", n, halt, modelHalt);
      end
    end
  endtask

  initial begin
    rst_in    = 1'b1;
    rdy_in    = 1'b0;
    mem_addr  = 32'h0;
    mem_write = 8'h00;
    r_nw_in   = 1'b0;
    tx_ready  = 1'b0;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    $display("[TB] starting mem_responder bench");
    test_reset();
    test_ram_basic();
    test_addr_zero();
    test_rx();
    test_tx_fill();
    test_push_pop_full();
    test_halt();
    test_random_traffic();
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 17: RAM byte-address width (2^ADDR_WIDTH bytes).
REQ-002 Parameter TX_DEPTH, default 8: TX FIFO entries, power of two.
REQ-003 clk_in  input  1  single clock; all state updates on posedge.
REQ-004 rst_in  input  1  reset, synchronous and active-high.
REQ-005 rdy_in  input  1  global enable; low = hold all state.
REQ-006 mem_addr  input  32  byte address from memory controller.
REQ-007 mem_write  input  8  write byte.
REQ-008 r_nw_in  input  1  1 = read, 0 = write.
REQ-009 mem_read  output  8  read byte, registered.
REQ-010 io_buffer_full  output  1  back-pressure to controller.
REQ-011 tx_data  output  8  UART transmit byte.
REQ-012 tx_valid  output  1  tx_data valid.
REQ-013 tx_ready  input  1  sink accepts tx_data.
REQ-014 rx_data  input  8  UART receive byte.
REQ-015 rx_valid  input  1  rx_data valid; held until consumed.
REQ-016 rx_pop  output  1  one-cycle pulse consuming rx_data.
REQ-017 halt  output  1  program-end flag, sticky.

Function
REQ-018 Decode: mem_addr[17:16]==2'b11 selects IO space; otherwise RAM at mem_addr[ADDR_WIDTH-1:0].
REQ-019 Commit rule: a bus transaction commits only in a cycle with rdy_in=1; rdy_in=0 leaves RAM, FIFO, mem_read, halt unchanged and rx_pop=0.
REQ-020 RAM read: mem_read shall equal RAM byte at the address presented in the previous committed cycle (1-cycle latency).
REQ-021 RAM write: mem_write shall be stored at the decoded address at the committing edge; mem_read after a write cycle shall be 8'h00.
REQ-022 Writes to address 32'h0 shall be discarded (idle bus drives write/addr 0/data 0).
REQ-023 IO write 0x30000: push mem_write into TX FIFO; if FIFO full, byte dropped and count unchanged.
REQ-024 IO write 0x30004: set halt=1; halt remains 1 until reset.
REQ-025 IO read 0x30000: if rx_valid, mem_read next cycle = rx_data and rx_pop pulses 1 in the commit cycle; else mem_read next cycle = 8'h00, no pop.
REQ-026 IO read 0x30004: mem_read next cycle = {6'b0, tx FIFO full, rx_valid}.
REQ-027 Other IO addresses: writes ignored, reads return 8'h00.
REQ-028 TX FIFO: head drives tx_data; tx_valid = (count!=0); entry popped when tx_valid && tx_ready at a committing edge.
REQ-029 Simultaneous push and pop: count unchanged, both performed, including when full (pop frees the slot first).
REQ-030 Pointers wrap modulo TX_DEPTH; count range 0..TX_DEPTH.
REQ-031 io_buffer_full = registered (count >= TX_DEPTH-2), so a write already in flight never overflows the FIFO.
REQ-032 tx_ready and rx_valid are sampled only at committing edges.

Reset
REQ-033 On rst_in=1 at a clock edge: mem_read=8'h00, io_buffer_full=0, tx_valid=0, tx_data=8'h00, rx_pop=0, halt=0, FIFO pointers and count=0.
REQ-034 RAM contents are not cleared by reset.
REQ-035 Reset overrides rdy_in and any concurrent bus transaction; a write presented in the reset cycle is not committed.

Verification
REQ-036 Write 0xA5 to 0x00010, next cycle read 0x00010 -> mem_read=0xA5 one cycle after the read address.
REQ-037 Write 0x55 to 0x00000 then read 0x00000 -> mem_read equals preloaded value, not 0x55.
REQ-038 tx_ready=0, write bytes 1..8 to 0x30000 -> io_buffer_full=1 after 6th, count=8, 9th dropped; tx_ready=1 -> tx_data 1..8 in order.
REQ-039 rx_valid=1, rx_data=0x3C, read 0x30000 -> rx_pop pulse, mem_read=0x3C; rx_valid=0 read -> mem_read=0x00, no pulse.
REQ-040 Full FIFO with tx_ready=1 and write 0x77 same cycle -> count stays 8, 0x77 delivered last.
REQ-041 Write to 0x30004 with rdy_in=0 -> halt=0; repeat with rdy_in=1 -> halt=1; rst_in -> halt=0.
